// File: rtl/alarme_pkg.sv
// alarme_pkg: shared encodings and defaults for the controle_alarme anti-theft sequencer.
// Contents: state_t (3-bit state codes, also visible on state_o), time_sel codes,
// and the reset values of the four programmable delays (in seconds).
package alarme_pkg;

  // State codes are fixed because they leave the block on state_o for debug.
  typedef enum logic [2:0] {
    ST_ARMED      = 3'd0,
    ST_TRIGGERED  = 3'd1,
    ST_SOUND      = 3'd2,
    ST_DISARMED   = 3'd3,
    ST_WAIT_OPEN  = 3'd4,
    ST_WAIT_CLOSE = 3'd5,
    ST_ARM_DELAY  = 3'd6
  } state_t;

  // time_sel codes for the reprogram strobe
  localparam logic [1:0] SEL_ARM    = 2'd0;
  localparam logic [1:0] SEL_DRIVER = 2'd1;
  localparam logic [1:0] SEL_PASS   = 2'd2;
  localparam logic [1:0] SEL_ALARM  = 2'd3;

  // Delay defaults, seconds
  localparam int DEF_T_ARM    = 6;
  localparam int DEF_T_DRIVER = 8;
  localparam int DEF_T_PASS   = 15;
  localparam int DEF_T_ALARM  = 10;

endpackage

// File: rtl/temporizador.sv
// temporizador: 1 s prescaler plus TW-bit countdown in seconds.
// Ports: clock, reset (async, active-high), load/value (start a countdown of value
// seconds and clear the prescaler), tick (1-cycle pulse at prescaler wrap), expired
// (1-cycle pulse, N*CLK_PER_SEC+1 cycles after a load of N). Loading 0 just idles it.
module temporizador #(
  parameter int CLK_PER_SEC = 100,
  parameter int TW          = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          tick,
  output logic          expired
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic [TW-1:0] count;

  // Combinational so the tick lines up with the last prescaler cycle of each second.
  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc   <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else if (load) begin
      // A new load restarts the second boundary as well, so the first tick
      // arrives a full CLK_PER_SEC cycles later.
      presc   <= '0;
      count   <= value;
      expired <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      // Registered: the pulse appears the cycle after the tick that reaches zero.
      expired <= tick && (count == TW'(1));
      if (tick && (count != '0)) begin
        count <= count - TW'(1);
      end
    end
  end

endmodule

// File: rtl/controle_alarme.sv
// controle_alarme: anti-theft sequencer gating the fuel-pump enable, siren and status LED.
// Ports: clock, reset (async, active-high); ignition, door_driver, door_pass inputs;
// reprogram/time_sel/time_val delay writes; pump_allow, siren, status_led, state_o.
// Build option: define SIREN_PULSE_EN for an intermittent siren (toggles each second).
module controle_alarme
  import alarme_pkg::*;
#(
  parameter int CLK_PER_SEC  = 100,
  parameter int TW           = 4,
  parameter int T_ARM_DEF    = DEF_T_ARM,
  parameter int T_DRIVER_DEF = DEF_T_DRIVER,
  parameter int T_PASS_DEF   = DEF_T_PASS,
  parameter int T_ALARM_DEF  = DEF_T_ALARM
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ignition,
  input  logic          door_driver,
  input  logic          door_pass,
  input  logic          reprogram,
  input  logic [1:0]    time_sel,
  input  logic [TW-1:0] time_val,
  output logic          pump_allow,
  output logic          siren,
  output logic          status_led,
  output logic [2:0]    state_o
);

  state_t        state;
  state_t        state_nxt;

  logic [TW-1:0] t_arm;
  logic [TW-1:0] t_driver;
  logic [TW-1:0] t_pass;
  logic [TW-1:0] t_alarm;

  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tick;
  logic          expired;

  // A zero delay would never expire, so it is stored as one second.
  logic [TW-1:0] time_val_clamped;
  assign time_val_clamped = (time_val == '0) ? TW'(1) : time_val;

  logic any_door;
  assign any_door = door_driver | door_pass;

  temporizador #(
    .CLK_PER_SEC (CLK_PER_SEC),
    .TW          (TW)
  ) u_tmr (
    .clock   (clock),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_value),
    .tick    (tick),
    .expired (expired)
  );

  // Next-state and timer-load decision. Priority in every state:
  // reprogram > ignition > doors > expired.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_value = '0;
    if (reprogram) begin
      // Loading zero clears the countdown without ever raising expired.
      state_nxt = ST_ARMED;
      tmr_load  = 1'b1;
    end else begin
      case (state)
        ST_ARMED: begin
          if (ignition) begin
            state_nxt = ST_DISARMED;
          end else if (door_driver) begin
            // Driver door wins when both open together.
            state_nxt = ST_TRIGGERED;
            tmr_load  = 1'b1;
            tmr_value = t_driver;
          end else if (door_pass) begin
            state_nxt = ST_TRIGGERED;
            tmr_load  = 1'b1;
            tmr_value = t_pass;
          end
        end
        ST_TRIGGERED: begin
          // Further door activity is ignored so the entry delay is not extended.
          if (ignition) begin
            state_nxt = ST_DISARMED;
          end else if (expired) begin
            state_nxt = ST_SOUND;
            tmr_load  = 1'b1;
            tmr_value = t_alarm;
          end
        end
        ST_SOUND: begin
          if (ignition) begin
            state_nxt = ST_DISARMED;
          end else if (any_door) begin
            // Keep the siren-hold countdown pinned while a door stays open.
            tmr_load  = 1'b1;
            tmr_value = t_alarm;
          end else if (expired) begin
            state_nxt = ST_ARMED;
          end
        end
        ST_DISARMED: begin
          if (!ignition) begin
            state_nxt = ST_WAIT_OPEN;
          end
        end
        ST_WAIT_OPEN: begin
          if (ignition) begin
            state_nxt = ST_DISARMED;
          end else if (door_driver) begin
            state_nxt = ST_WAIT_CLOSE;
          end
        end
        ST_WAIT_CLOSE: begin
          if (ignition) begin
            state_nxt = ST_DISARMED;
          end else if (!any_door) begin
            state_nxt = ST_ARM_DELAY;
            tmr_load  = 1'b1;
            tmr_value = t_arm;
          end
        end
        ST_ARM_DELAY: begin
          if (ignition) begin
            state_nxt = ST_DISARMED;
          end else if (any_door) begin
            // Exit delay restarts from scratch once the doors close again.
            state_nxt = ST_WAIT_CLOSE;
          end else if (expired) begin
            state_nxt = ST_ARMED;
          end
        end
        default: begin
          state_nxt = ST_ARMED;
        end
      endcase
    end
  end

`ifdef SIREN_PULSE_EN
  // Set while the previous cycle was in SOUND; distinguishes SOUND entry
  // (siren forced on) from a toggle-off phase.
  logic in_sound;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_ARMED;
      pump_allow <= 1'b0;
      siren      <= 1'b0;
      status_led <= 1'b0;
      t_arm      <= TW'(T_ARM_DEF);
      t_driver   <= TW'(T_DRIVER_DEF);
      t_pass     <= TW'(T_PASS_DEF);
      t_alarm    <= TW'(T_ALARM_DEF);
`ifdef SIREN_PULSE_EN
      in_sound   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      if (reprogram) begin
        case (time_sel)
          SEL_ARM:    t_arm    <= time_val_clamped;
          SEL_DRIVER: t_driver <= time_val_clamped;
          SEL_PASS:   t_pass   <= time_val_clamped;
          SEL_ALARM:  t_alarm  <= time_val_clamped;
          default:    t_arm    <= time_val_clamped;
        endcase
      end

      // Outputs are derived from the current state, so they trail state_o by one cycle.
      pump_allow <= (state == ST_DISARMED);

      if (state == ST_ARMED) begin
        status_led <= status_led ^ tick;
      end else begin
        status_led <= (state == ST_TRIGGERED) || (state == ST_SOUND);
      end

`ifdef SIREN_PULSE_EN
      in_sound <= (state == ST_SOUND);
      if (state == ST_SOUND) begin
        siren <= in_sound ? (siren ^ tick) : 1'b1;
      end else begin
        siren <= 1'b0;
      end
`else
      siren <= (state == ST_SOUND);
`endif
    end
  end

  assign state_o = state;

endmodule
